// File: rtl/flash_sequence_controller_pkg.sv
// Shared types, constants and helpers for the flash sequence controller:
// state encodings, the blank display code, digit mapping and BCD conversion.
package flash_sequence_controller_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    GEN      = 3'd1,
    SHOW_ON  = 3'd2,
    SHOW_OFF = 3'd3,
    ARM      = 3'd4,
    ANSWER   = 3'd5,
    WIN      = 3'd6,
    LOSE     = 3'd7
  } state_t;

  localparam logic [4:0] BLANK_CODE = 5'd16;

  // Folds a raw 4-bit value onto a decimal digit (10..15 -> 0..5).
  function automatic logic [3:0] map_digit(input logic [3:0] raw);
    return (raw < 4'd10) ? raw : raw - 4'd10;
  endfunction

  // Saturates at 99 and returns {tens, ones} in BCD.
  function automatic logic [7:0] secs_to_bcd(input int unsigned secs);
    int unsigned v;
    v = (secs > 99) ? 99 : secs;
    return {4'(v / 10), 4'(v % 10)};
  endfunction

endpackage

// File: rtl/flash_sequence_controller_if.sv
// Handshake bundle between the game datapath (master) and the flash
// sequence controller (slave).
interface flash_sequence_controller_if;

  logic       start_pulse;
  logic       abort_pulse;
  logic       replay_pulse;
  logic [3:0] level_num;
  logic [3:0] answer_in;
  logic       submit_pulse;
  logic       time_expired;
  logic [4:0] flash_digit;
  logic       timer_load;
  logic [7:0] timer_value;
  logic       timer_begin;
  logic       win;
  logic       loose;
  logic       busy;
  logic [3:0] progress;

  modport master (
    output start_pulse, abort_pulse, replay_pulse, level_num, answer_in,
           submit_pulse, time_expired,
    input  flash_digit, timer_load, timer_value, timer_begin, win, loose,
           busy, progress
  );

  modport slave (
    input  start_pulse, abort_pulse, replay_pulse, level_num, answer_in,
           submit_pulse, time_expired,
    output flash_digit, timer_load, timer_value, timer_begin, win, loose,
           busy, progress
  );

endinterface

// File: rtl/flash_sequence_controller_digit_lfsr.sv
// Free-running 16-bit Fibonacci LFSR (taps 16,14,13,11) that presents its
// low nibble folded onto a decimal digit.
module digit_lfsr
  import flash_sequence_controller_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic       clock,
  input  logic       rst,
  output logic [3:0] digit
);

  logic [15:0] lfsr_q;

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) lfsr_q <= SEED;
    else      lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  assign digit = map_digit(lfsr_q[3:0]);

endmodule

// File: rtl/flash_sequence_controller.sv
// Memory-test round sequencer: generate, flash, arm timer, check answers.
// Optional one-shot re-flash during ANSWER when FLASH_REPLAY_EN is defined.
module flash_sequence_controller
  import flash_sequence_controller_pkg::*;
#(
  parameter int unsigned FLASH_ON_CYCLES  = 25000000,
  parameter int unsigned FLASH_OFF_CYCLES = 12500000,
  parameter int unsigned BASE_LEN         = 3,
  parameter int unsigned MAX_LEN          = 12,
  parameter int unsigned SECS_PER_DIGIT   = 3,
  parameter logic [15:0] LFSR_SEED        = 16'hACE1
) (
  input logic                        clock,
  input logic                        rst,
  flash_sequence_controller_if.slave bus
);

  localparam logic [24:0] ON_RELOAD  = 25'(FLASH_ON_CYCLES - 1);
  localparam logic [24:0] OFF_RELOAD = 25'(FLASH_OFF_CYCLES - 1);

  state_t      state;
  logic        arm_second;
  logic [4:0]  len;
  logic [3:0]  index;
  logic [24:0] flash_cnt;
  logic [3:0]  buffer [MAX_LEN];
  logic [3:0]  gen_digit;

  logic [4:0]  flash_digit_q;
  logic        timer_load_q;
  logic [7:0]  timer_value_q;
  logic        timer_begin_q;
  logic        win_q;
  logic        loose_q;
  logic [3:0]  progress_q;

  logic [4:0]  len_req;
  logic [4:0]  len_cap;
  logic        last_index;
  logic        start_take;

  digit_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clock (clock),
    .rst   (rst),
    .digit (gen_digit)
  );

  assign len_req    = 5'(BASE_LEN) + {1'b0, bus.level_num};
  assign len_cap    = (len_req > 5'(MAX_LEN)) ? 5'(MAX_LEN) : len_req;
  assign last_index = ({1'b0, index} == len - 5'd1);
  assign start_take = (state == IDLE) && bus.start_pulse && !bus.abort_pulse;

`ifdef FLASH_REPLAY_EN
  logic replay_used;
  logic replay_take;

  assign replay_take = (state == ANSWER) && bus.replay_pulse && !replay_used
                       && !bus.time_expired && !bus.abort_pulse;

  always_ff @(posedge clock or negedge rst) begin
    if (!rst)             replay_used <= 1'b0;
    else if (start_take)  replay_used <= 1'b0;
    else if (replay_take) replay_used <= 1'b1;
  end
`endif

  // NOTE: the digit buffer has no reset; it is always written in GEN before
  // any read, and leaving it out of reset lets it map onto plain storage.
  always_ff @(posedge clock) begin
    if (state == GEN) buffer[index] <= gen_digit;
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      arm_second    <= 1'b0;
      len           <= '0;
      index         <= '0;
      flash_cnt     <= '0;
      flash_digit_q <= BLANK_CODE;
      timer_load_q  <= 1'b0;
      timer_value_q <= '0;
      timer_begin_q <= 1'b0;
      win_q         <= 1'b0;
      loose_q       <= 1'b0;
      progress_q    <= '0;
    end else begin
      timer_load_q  <= 1'b0;
      timer_begin_q <= 1'b0;
      win_q         <= 1'b0;
      loose_q       <= 1'b0;

      if (bus.abort_pulse) begin
        state         <= IDLE;
        arm_second    <= 1'b0;
        flash_digit_q <= BLANK_CODE;
      end else begin
        unique case (state)
          IDLE: begin
            if (start_take) begin
              state      <= GEN;
              len        <= len_cap;
              index      <= '0;
              progress_q <= '0;
            end
          end

          GEN: begin
            if (last_index) begin
              state         <= SHOW_ON;
              index         <= '0;
              flash_cnt     <= ON_RELOAD;
              // A one-digit round would read buffer[0] on the edge that writes it.
              flash_digit_q <= {1'b0, (index == 4'd0) ? gen_digit : buffer[0]};
            end else begin
              index <= index + 4'd1;
            end
          end

          SHOW_ON: begin
            if (flash_cnt == '0) begin
              state         <= SHOW_OFF;
              flash_cnt     <= OFF_RELOAD;
              flash_digit_q <= BLANK_CODE;
            end else begin
              flash_cnt <= flash_cnt - 25'd1;
            end
          end

          SHOW_OFF: begin
            if (flash_cnt != '0) begin
              flash_cnt <= flash_cnt - 25'd1;
            end else if (last_index) begin
              state         <= ARM;
              arm_second    <= 1'b0;
              timer_load_q  <= 1'b1;
              timer_value_q <= secs_to_bcd(int'(len) * SECS_PER_DIGIT);
            end else begin
              state         <= SHOW_ON;
              index         <= index + 4'd1;
              flash_cnt     <= ON_RELOAD;
              flash_digit_q <= {1'b0, buffer[index + 4'd1]};
            end
          end

          ARM: begin
            if (!arm_second) begin
              arm_second    <= 1'b1;
              timer_begin_q <= 1'b1;
            end else begin
              arm_second <= 1'b0;
              state      <= ANSWER;
              index      <= '0;
            end
          end

          ANSWER: begin
            if (bus.time_expired) begin
              state   <= LOSE;
              loose_q <= 1'b1;
            end
`ifdef FLASH_REPLAY_EN
            else if (replay_take) begin
              state         <= SHOW_ON;
              index         <= '0;
              progress_q    <= '0;
              flash_cnt     <= ON_RELOAD;
              flash_digit_q <= {1'b0, buffer[0]};
            end
`endif
            else if (bus.submit_pulse) begin
              if (bus.answer_in == buffer[index]) begin
                progress_q <= progress_q + 4'd1;
                if (last_index) begin
                  state <= WIN;
                  win_q <= 1'b1;
                end else begin
                  index <= index + 4'd1;
                end
              end else begin
                state   <= LOSE;
                loose_q <= 1'b1;
              end
            end
          end

          WIN:     state <= IDLE;
          LOSE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.flash_digit = flash_digit_q;
  assign bus.timer_load  = timer_load_q;
  assign bus.timer_value = timer_value_q;
  assign bus.timer_begin = timer_begin_q;
  assign bus.win         = win_q;
  assign bus.loose       = loose_q;
  assign bus.busy        = (state != IDLE);
  assign bus.progress    = progress_q;

endmodule

// File: doc/flash_sequence_controller.md
Name: flash_sequence_controller

Overview:
Sequences one memory-test round for the game datapath. On start it generates a level-dependent digit sequence and buffers it, then flashes the digits on the flash display. It then loads and starts the two-digit countdown timer and checks the player's answers digit by digit. It emits win/loose pulses that the level table and score table consume.

Parameters:
FLASH_ON_CYCLES, 25000000, clock cycles each digit is shown
FLASH_OFF_CYCLES, 12500000, blank gap cycles after each digit
BASE_LEN, 3, sequence length at level 0
MAX_LEN, 12, buffer depth and length cap
SECS_PER_DIGIT, 3, timer seconds granted per digit
LFSR_SEED, 16'hACE1, LFSR reset value; must be nonzero

Ports:
clock  in  1  system clock
rst  in  1  asynchronous active-low reset
start_pulse  in  1  one-cycle pulse, begins a round (shaped auth pulse)
abort_pulse  in  1  one-cycle pulse, logout/abort
replay_pulse  in  1  one-cycle pulse, request re-flash (see Optional Feature)
level_num  in  4  current level, sampled at start
answer_in  in  4  player digit from toggles
submit_pulse  in  1  one-cycle pulse, commit answer_in
time_expired  in  1  level, timer reached zero
flash_digit  out  5  0-9 = digit, 16 = blank (seven_seg5 code)
timer_load  out  1  one-cycle pulse, load timer_value
timer_value  out  8  BCD seconds, high nibble tens
timer_begin  out  1  one-cycle pulse, start countdown
win  out  1  one-cycle pulse, round passed
loose  out  1  one-cycle pulse, round failed
busy  out  1  high in every state except IDLE
progress  out  4  count of correct answers so far

Behaviour:
- Reset (rst=0, async) values:
  - state IDLE; all pulse outputs 0; flash_digit=16; timer_value=0; progress=0.
  - LFSR=LFSR_SEED; buffer contents don't-care.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Advances every clock in every state, so the sequence depends on start timing.
- Round length: len = min(BASE_LEN + level_num, MAX_LEN). Computed in 5 bits, latched at start.
- Digit mapping: d = lfsr[3:0] if < 10, else lfsr[3:0] - 10.
- States:
  - IDLE: start_pulse -> GEN; latch len; clear index and progress.
  - GEN: write one digit per cycle into buffer[index]; after len cycles -> SHOW_ON, index=0.
  - SHOW_ON: flash_digit=buffer[index] for FLASH_ON_CYCLES -> SHOW_OFF.
  - SHOW_OFF: flash_digit=16 for FLASH_OFF_CYCLES. If index=len-1 -> ARM, else index+1 -> SHOW_ON.
  - ARM:
    - cycle 1: timer_load=1, timer_value = BCD(min(len*SECS_PER_DIGIT, 99)).
    - cycle 2: timer_begin=1 -> ANSWER, index=0.
  - ANSWER: on submit_pulse compare answer_in with buffer[index].
    - Match: progress+1, index+1; if index=len-1 -> WIN.
    - Mismatch -> LOSE.
  - ANSWER, time_expired=1 -> LOSE.
  - WIN: win=1 for one cycle -> IDLE.
  - LOSE: loose=1 for one cycle -> IDLE.
- progress holds its value in IDLE until the next start.
- Priorities:
  - abort_pulse in any state -> IDLE next cycle; no win/loose; flash_digit=16.
  - Abort beats all other inputs.
  - time_expired beats submit_pulse in the same cycle -> LOSE.
- start_pulse while busy: ignored.
- submit_pulse outside ANSWER: ignored.
- level_num changes after start have no effect.
- Flash timers: one 25-bit down-counter, reloaded on each SHOW_ON/SHOW_OFF entry.
- Latency from start_pulse to first digit shown: len+1 cycles.

Optional Feature:
Macro FLASH_REPLAY_EN.
- Defined: one replay_pulse per round is honoured in ANSWER.
  - Effect: index=0, progress=0, -> SHOW_ON, then ARM reloads the timer at full value.
  - A second replay in the same round is ignored.
- Undefined: replay_pulse ignored; no replay-used flag is synthesized.

Decomposition:
- Shared include game_defs.vh holds:
  - state encodings (3-bit localparams IDLE..LOSE);
  - blank code 5'd16;
  - BCD helper function for timer_value.
- One sub-module: digit_lfsr (16-bit LFSR with seed parameter, outputs raw state and mapped digit).

Test Plan:
All scenarios use FLASH_ON_CYCLES=4, FLASH_OFF_CYCLES=2.
1. level_num=2, start_pulse:
   - len=5; flash_digit shows 5 digits, each 4 cycles then 16 for 2 cycles.
   - timer_load with timer_value=8'h15; timer_begin on the next cycle.
2. Submit all 5 buffered digits correctly -> progress 1..5; single-cycle win; busy drops; loose stays 0.
3. Submit a correct first digit, then a wrong second digit -> progress=1; single-cycle loose; state IDLE.
4. level_num=15 -> len capped at 12, timer_value=8'h36. Assert time_expired and submit_pulse in the same cycle -> loose, no progress increment.
5. abort_pulse mid SHOW_ON -> next cycle IDLE, flash_digit=16, no win/loose. A later start_pulse begins a fresh round.
6. FLASH_REPLAY_EN defined, replay_pulse in ANSWER after 1 correct answer:
   - progress=0, sequence re-flashed, timer reloaded to 8'h15.
   - A second replay_pulse has no effect.
   - Undefined build: replay_pulse has no effect.
